// File: rtl/ram_fifo_if.sv
// Stream and ram-side signal bundle for ram_fifo_ctrl.
// slave: the controller's view. master: the view of whatever drives the
// input stream, consumes the output stream and hosts the ram.
interface ram_fifo_if #(
  parameter int DATA_BITWIDTH = 8,
  parameter int ADDR_BITWIDTH = 8
);
  logic [DATA_BITWIDTH-1:0] in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic [DATA_BITWIDTH-1:0] out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [ADDR_BITWIDTH-1:0] ram_addr_wr;
  logic [DATA_BITWIDTH-1:0] ram_data_wr;
  logic                     ram_wr;
  logic [ADDR_BITWIDTH-1:0] ram_addr_rd;
  logic [DATA_BITWIDTH-1:0] ram_data_rd;
  logic [ADDR_BITWIDTH:0]   count;
  logic                     full;
  logic                     empty;

  modport slave (
    input  in_data, in_valid, out_ready, ram_data_rd,
    output in_ready, out_data, out_valid, ram_addr_wr, ram_data_wr, ram_wr,
           ram_addr_rd, count, full, empty
  );

  modport master (
    output in_data, in_valid, out_ready, ram_data_rd,
    input  in_ready, out_data, out_valid, ram_addr_wr, ram_data_wr, ram_wr,
           ram_addr_rd, count, full, empty
  );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// Write/read controller in front of an edge-written, async-read ram.
// Each accepted word is written with a three-cycle setup/strobe sequence so
// address and data are stable before and during the rising edge of ram_wr.
// Committed words are drained into a registered valid/ready output.
//
// state    | meaning
// W_IDLE   | waiting for an input word; in_ready = !full
// W_SETUP  | addr/data latched, ram_wr still low
// W_STROBE | ram_wr high; leaving this state commits the word
module ram_fifo_ctrl #(
  parameter int DATA_BITWIDTH = 8,
  parameter int ADDR_BITWIDTH = 8,
  parameter int DEPTH         = 1 << ADDR_BITWIDTH
) (
  input logic        clk,
  input logic        rst,
  ram_fifo_if.slave  bus
);

  localparam logic [ADDR_BITWIDTH-1:0] LAST_PTR  = ADDR_BITWIDTH'(DEPTH - 1);
  localparam logic [ADDR_BITWIDTH:0]   DEPTH_CNT = (ADDR_BITWIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {
    W_IDLE,
    W_SETUP,
    W_STROBE
  } w_state_t;

  w_state_t                 state, state_nxt;
  logic [ADDR_BITWIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_BITWIDTH:0]   count_q;
  logic                     ram_wr_q, ram_wr_nxt;
  logic [ADDR_BITWIDTH-1:0] addr_wr_q;
  logic [DATA_BITWIDTH-1:0] data_wr_q;
  logic                     out_valid_q;
  logic [DATA_BITWIDTH-1:0] out_data_q;
  logic                     full_c;
  logic                     in_ready_c;
  logic                     accept;
  logic                     commit;
  logic                     load;

  // Explicit wrap so DEPTH does not have to be a power of two.
  function automatic logic [ADDR_BITWIDTH-1:0] next_ptr(input logic [ADDR_BITWIDTH-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign full_c     = (count_q == DEPTH_CNT);
  assign in_ready_c = (state == W_IDLE) && !full_c;
  // Only committed entries are loaded, so rd_ptr never overtakes a pending strobe.
  assign load       = (count_q != '0) && (!out_valid_q || bus.out_ready);

  // Write sequencer: next state, accept/commit strobes, next ram_wr level.
  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    commit     = 1'b0;
    ram_wr_nxt = 1'b0;
    case (state)
      W_IDLE: begin
        if (bus.in_valid && in_ready_c) begin
          accept    = 1'b1;
          state_nxt = W_SETUP;
        end
      end
      W_SETUP: begin
        ram_wr_nxt = 1'b1;
        state_nxt  = W_STROBE;
      end
      W_STROBE: begin
        commit    = 1'b1;
        state_nxt = W_IDLE;
      end
      default: state_nxt = W_IDLE;
    endcase
  end

  // Write-side registers: state, registered strobe, held address/data, write pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= W_IDLE;
      ram_wr_q  <= 1'b0;
      addr_wr_q <= '0;
      data_wr_q <= '0;
      wr_ptr    <= '0;
    end else begin
      state    <= state_nxt;
      ram_wr_q <= ram_wr_nxt;
      if (accept) begin
        addr_wr_q <= wr_ptr;
        data_wr_q <= bus.in_data;
      end
      if (commit) wr_ptr <= next_ptr(wr_ptr);
    end
  end

  // Output register: load from the async read port or drop valid once taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      rd_ptr      <= '0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_data_q  <= bus.ram_data_rd;
      rd_ptr      <= next_ptr(rd_ptr);
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Occupancy: commits add, loads remove, both together cancel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      case ({commit, load})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.out_data    = out_data_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.ram_addr_wr = addr_wr_q;
  assign bus.ram_data_wr = data_wr_q;
  assign bus.ram_wr      = ram_wr_q;
  assign bus.ram_addr_rd = rd_ptr;
  assign bus.count       = count_q;
  assign bus.full        = full_c;
  assign bus.empty       = (count_q == '0);

endmodule
